// File: rtl/hazard_ctrl_seq.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_seq
// Pipeline hazard sequencer for a 5-stage in-order core. It inserts
// load-use bubbles, flushes on taken branches and holds the whole pipe
// while data memory is busy. It remembers which state it was in when a
// memory wait started, and resumes that state once the wait ends.
//
// Ports
//   i_clk, i_rst              clock (rising edge), synchronous active-high reset
//   i_ifid_rs1/rs2            source registers of the instruction in ID
//   i_ifid_use_rs1/rs2        instruction in ID reads that source
//   i_idex_rd                 destination of the instruction in EX
//   i_idex_mem_read           instruction in EX is a load
//   i_take_branch             EX resolved a taken branch / jump
//   i_dmem_busy               data memory not ready, hold everything
//   o_pc_write, o_ifid_write  PC and IF/ID enables
//   o_ifid_flush              IF/ID loads a NOP
//   o_idex_flush              ID/EX control cleared (bubble)
//   o_pipe_hold               EX/MEM and MEM/WB enables deasserted
//   o_pc_sel_target           PC mux selects the branch target
//   o_state                   FSM state for debug
//   o_stall_cnt, o_flush_cnt, o_mwait_cnt
//                             saturating event counters, present only when
//                             HAZARD_PERF_CNT_EN is defined
//
// States
//   state  | meaning
//   RUN    | normal flow, load-use detection active
//   LSTALL | inserting the remaining load-use bubbles
//   MWAIT  | data memory busy, previous state kept in r_saved
//   (3)    | unused, goes back to RUN on the next cycle
// ---------------------------------------------------------------------------
module hazard_ctrl_seq #(
  parameter int AW                = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-1:0] i_ifid_rs1,
  input  logic [AW-1:0] i_ifid_rs2,
  input  logic          i_ifid_use_rs1,
  input  logic          i_ifid_use_rs2,
  input  logic [AW-1:0] i_idex_rd,
  input  logic          i_idex_mem_read,
  input  logic          i_take_branch,
  input  logic          i_dmem_busy,
  output logic          o_pc_write,
  output logic          o_ifid_write,
  output logic          o_ifid_flush,
  output logic          o_idex_flush,
  output logic          o_pipe_hold,
  output logic          o_pc_sel_target,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_mwait_cnt,
`endif
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_LSTALL = 2'd1,
    S_MWAIT  = 2'd2,
    S_ILL    = 2'd3
  } state_t;

  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_t     r_state, r_saved;
  logic [2:0] r_cnt;

  state_t     w_nxt_state, w_nxt_saved, w_eff;
  logic [2:0] w_nxt_cnt;
  logic       w_hit;
  logic       w_pc_write, w_ifid_write, w_ifid_flush, w_idex_flush;
  logic       w_pipe_hold, w_pc_sel_target;

  assign w_hit = i_idex_mem_read && (i_idex_rd != '0) &&
                 ((i_ifid_use_rs1 && (i_ifid_rs1 == i_idex_rd)) ||
                  (i_ifid_use_rs2 && (i_ifid_rs2 == i_idex_rd)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_RUN;
      r_saved <= S_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_nxt_state;
      r_saved <= w_nxt_saved;
      r_cnt   <= w_nxt_cnt;
    end
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_saved     = r_saved;
    w_nxt_cnt       = r_cnt;
    w_pc_write      = 1'b1;
    w_ifid_write    = 1'b1;
    w_ifid_flush    = 1'b0;
    w_idex_flush    = 1'b0;
    w_pipe_hold     = 1'b0;
    w_pc_sel_target = 1'b0;
    // Leaving MWAIT costs no cycle: the saved state decides this cycle.
    w_eff           = (r_state == S_MWAIT) ? r_saved : r_state;

    if (i_dmem_busy) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_pipe_hold  = 1'b1;
      w_nxt_state  = S_MWAIT;
      // Only the first busy cycle records where to resume; the counter is
      // left untouched so the bubble count survives the wait.
      if (r_state != S_MWAIT)
        w_nxt_saved = (r_state == S_LSTALL) ? S_LSTALL : S_RUN;
    end else if (i_take_branch) begin
      w_pc_sel_target = 1'b1;
      w_ifid_flush    = 1'b1;
      w_idex_flush    = 1'b1;
      w_nxt_state     = S_RUN;
      w_nxt_cnt       = 3'd0;
    end else begin
      case (w_eff)
        S_LSTALL: begin
          // EX holds a bubble here, so the load-use compare is not looked at.
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_idex_flush = 1'b1;
          if (r_cnt > 3'd1) begin
            w_nxt_cnt   = r_cnt - 3'd1;
            w_nxt_state = S_LSTALL;
          end else begin
            w_nxt_cnt   = 3'd0;
            w_nxt_state = S_RUN;
          end
        end
        S_RUN: begin
          w_nxt_state = S_RUN;
          if (w_hit) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              w_nxt_state = S_LSTALL;
              w_nxt_cnt   = STALL_INIT;
            end
          end
        end
        default: begin
          w_nxt_state = S_RUN;
          w_nxt_cnt   = 3'd0;
        end
      endcase
    end
  end

  // Reset forces the plain RUN picture on every output.
  assign o_pc_write      = i_rst | w_pc_write;
  assign o_ifid_write    = i_rst | w_ifid_write;
  assign o_ifid_flush    = ~i_rst & w_ifid_flush;
  assign o_idex_flush    = ~i_rst & w_idex_flush;
  assign o_pipe_hold     = ~i_rst & w_pipe_hold;
  assign o_pc_sel_target = ~i_rst & w_pc_sel_target;
  assign o_state         = i_rst ? S_RUN : r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_mwait_cnt;
  logic             w_bubble;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A bubble is an ID/EX clear that is not part of a branch flush.
  assign w_bubble = w_idex_flush & ~w_ifid_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_mwait_cnt <= '0;
    end else begin
      if (w_bubble && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_pc_sel_target && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      if (w_pipe_hold && !(&r_mwait_cnt))
        r_mwait_cnt <= r_mwait_cnt + CNT_ONE;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
  assign o_mwait_cnt = r_mwait_cnt;
`endif

endmodule

// File: doc/hazard_ctrl_seq.md
HAZARD_CTRL_SEQ -- requirements
Module: hazard_ctrl_seq

Interface
REQ-001 Parameter AW, default 5: register-address width.
REQ-002 Parameter LOAD_STALL_CYCLES, default 1, legal 1..7: bubbles inserted per load-use hazard.
REQ-003 Parameter CNT_W, default 16: performance-counter width (used only with REQ-033).
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ifid_rs1, ifid_rs2  in  AW each  source registers of the instruction in ID.
REQ-007 ifid_use_rs1, ifid_use_rs2  in  1 each  instruction in ID reads that source.
REQ-008 idex_rd  in  AW  destination of the instruction in EX.
REQ-009 idex_mem_read  in  1  instruction in EX is a load.
REQ-010 take_branch  in  1  EX resolved a taken branch or JAL/JALR.
REQ-011 dmem_busy  in  1  data memory not ready; whole pipeline must hold.
REQ-012 pc_write  out  1  PC register enable.
REQ-013 ifid_write  out  1  IF/ID register enable.
REQ-014 ifid_flush  out  1  IF/ID loads a NOP.
REQ-015 idex_flush  out  1  ID/EX control fields cleared (bubble).
REQ-016 pipe_hold  out  1  EX/MEM and MEM/WB enables deasserted.
REQ-017 pc_sel_target  out  1  PC mux selects the EX branch target.
REQ-018 state  out  2  FSM state encoding for debug.

Function
REQ-019 States: RUN=0, LSTALL=1, MWAIT=2; encoding 3 unused and SHALL return to RUN the next cycle.
REQ-020 Load-use hit = idex_mem_read && idex_rd!=0 && ((ifid_use_rs1 && ifid_rs1==idex_rd) || (ifid_use_rs2 && ifid_rs2==idex_rd)).
REQ-021 Priority, evaluated combinationally in the current cycle: dmem_busy > take_branch > load-use hit > normal.
REQ-022 Normal: pc_write=1, ifid_write=1, all flushes 0, pipe_hold=0, pc_sel_target=0.
REQ-023 dmem_busy=1 in any state: pc_write=0, ifid_write=0, idex_flush=0, ifid_flush=0, pipe_hold=1, pc_sel_target=0. The state and stall counter SHALL be frozen; MWAIT SHALL be entered, with the pre-wait state saved.
REQ-024 MWAIT with dmem_busy=0: return to the saved state in the same cycle and evaluate that state's outputs; exit latency is zero cycles.
REQ-025 take_branch=1 (no dmem_busy): pc_sel_target=1, pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1 for exactly that cycle. The state SHALL be forced to RUN and the stall counter cleared.
REQ-026 Load-use hit in RUN: first bubble in the same cycle (pc_write=0, ifid_write=0, idex_flush=1). If LOAD_STALL_CYCLES>1, go to LSTALL with counter=LOAD_STALL_CYCLES-1.
REQ-027 LSTALL: same outputs as REQ-026; counter decrements each non-held cycle; exit to RUN on the cycle the counter reaches 1. Total bubbles SHALL equal LOAD_STALL_CYCLES.
REQ-028 Load-use comparison SHALL be ignored while in LSTALL, because EX holds a bubble.
REQ-029 The stall counter SHALL be 3 bits; there is no wrap-around; it is never decremented below 1.

Reset
REQ-030 rst=1 at a clock edge: state=RUN, counter=0, saved state=RUN, performance counters=0. rst overrides every other input, including mid-LSTALL and mid-MWAIT.
REQ-031 While rst=1, outputs SHALL show the RUN normal values of REQ-022, regardless of the other inputs.

Configuration
REQ-032 Macro HAZARD_PERF_CNT_EN selects the performance counters.
REQ-033 With HAZARD_PERF_CNT_EN defined, add outputs stall_cnt, flush_cnt and mwait_cnt (CNT_W each).
- stall_cnt increments per load-use bubble cycle.
- flush_cnt increments per take_branch flush cycle.
- mwait_cnt increments per dmem_busy cycle.
- All three saturate at all-ones.
REQ-034 Without the macro, these ports and their registers SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-035 LOAD_STALL_CYCLES=1; load x5 in EX, ID reads rs1=x5 -> one cycle with pc_write=0, idex_flush=1, then normal; state stays RUN.
REQ-036 LOAD_STALL_CYCLES=3; same hazard -> exactly 3 bubble cycles; state sequence RUN,LSTALL,LSTALL,RUN.
REQ-037 idex_rd=0 with idex_mem_read=1 and ifid_rs1=0 -> no stall; also, a match on rs2 with ifid_use_rs2=0 -> no stall.
REQ-038 take_branch=1 together with a load-use hit -> a flush cycle with pc_sel_target=1, ifid_flush=1, idex_flush=1 and no bubble.
REQ-039 LOAD_STALL_CYCLES=3; dmem_busy held for 4 cycles during the 2nd bubble -> pipe_hold=1 for those 4 cycles, then the remaining 2 bubbles, for 3 bubbles total.
REQ-040 rst asserted during LSTALL -> state=RUN after the edge. With HAZARD_PERF_CNT_EN, counters=0; after 2 branches flush_cnt=2.
